prog_mem_ctrl: RTL and testbench
================================

Name: prog_mem_ctrl

Overview:
- Parametrised instruction memory with a controller, for the CPU fetch path; successor to the fixed 16x26 instruction store.
- Adds auto-clear on reset release, a streaming loader with an auto-incrementing write pointer, registered reads with a valid flag, and out-of-range address detection.
- Sits between the program loader (testbench or boot logic) and the fetch stage, which drives prog_pointer and consumes opcode.

Parameters:
- DATA_W, 26, opcode/word width in bits.
- ADDR_W, 4, address width.
- DEPTH, 16, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- write_data  in  1  write strobe; one word per asserted cycle.
- wr_auto  in  1  1 = write at the internal stream pointer; 0 = write at wr_addr.
- wr_addr  in  ADDR_W  explicit write address, used when wr_auto=0.
- data_to_write  in  DATA_W  write data.
- load_restart  in  1  returns the stream pointer to 0.
- rd_en  in  1  fetch request.
- prog_pointer  in  ADDR_W  fetch address.
- opcode  out  DATA_W  registered read data.
- opcode_valid  out  1  opcode is valid this cycle.
- ready  out  1  controller is in RUN and accepts reads and writes.
- load_count  out  ADDR_W+1  current stream pointer (number of words streamed).
- load_full  out  1  load_count == DEPTH.
- addr_err  out  1  one-cycle pulse on an out-of-range read or write, or a stream write while full.

Behaviour:
- Reset (async assert, synchronous release): state=CLEAR, clr_ptr=0, opcode=0, opcode_valid=0, ready=0, load_count=0, addr_err=0.
- FSM CLEAR: writes 0 to word clr_ptr each cycle. At clr_ptr==DEPTH-1, go to RUN on the next edge. CLEAR takes exactly DEPTH cycles. write_data and rd_en are ignored; no addr_err is raised.
- FSM RUN: ready=1. No other transitions; only reset leaves RUN.
- Reset asserted mid-CLEAR or mid-RUN restarts CLEAR from word 0.
- Write, wr_auto=0: if wr_addr < DEPTH, mem[wr_addr] is updated at the edge. Otherwise nothing is written and addr_err pulses the next cycle.
- Write, wr_auto=1: if load_full=0, mem[load_count] is written and load_count increments. If full, nothing is written, the pointer holds, and addr_err pulses.
- load_restart has priority over a same-cycle streaming increment: the pointer goes to 0 and that cycle's write uses the pre-restart address.
- Read: rd_en sampled at edge N gives opcode and opcode_valid=1 after edge N, i.e. latency 1.
- With rd_en=0, opcode_valid=0 and opcode holds its last value.
- Back-to-back reads give one result per cycle.
- Out-of-range read: opcode=0, opcode_valid=1, addr_err pulses.
- Read and write to the same address in the same cycle: write-first, so opcode returns the new data.
- An out-of-range read and write in the same cycle produce a single addr_err pulse.
- load_count saturates at DEPTH; it never wraps.

Optional Feature:
- Macro: PROG_MEM_PARITY_EN.
- When defined: each word stores an extra even-parity bit computed from data_to_write, and output port parity_err (1 bit) is added.
- parity_err is registered alongside opcode_valid and is 1 when the stored parity mismatches the read data. CLEAR writes parity 0.
- When undefined: no parity storage and no parity_err port; behaviour is otherwise identical.

Decomposition:
- Package prog_mem_pkg holds:
  - the FSM state typedef (CLEAR, RUN);
  - default width constants;
  - the function that computes parity.
- One sub-module, prog_mem_array: the storage with one write port and one synchronous write-first read port, parametrised by DATA_W/ADDR_W/DEPTH.
- The FSM, stream pointer and error logic stay in the top module.

Test Plan:
- Reset release with DEPTH=10 -> ready rises exactly 10 cycles later. Then read addresses 0..9 -> every opcode=0, opcode_valid=1.
- Stream 10 words alternating 0x5555/0xAAAA with wr_auto=1 -> load_count 1..10 and load_full=1 after word 10. An 11th write gives addr_err=1 and no change to memory. Reading 0..9 returns the alternating pattern with 1-cycle latency.
- Same-cycle write 0x2AAAAAA and read at address 3 -> opcode=0x2AAAAAA on the next cycle.
- With DEPTH=10, write at wr_addr=12 and read at prog_pointer=15 -> single addr_err pulse, opcode=0, and addresses 0..9 unchanged.
- Assert reset after 5 streamed words -> all outputs go to 0 immediately, CLEAR reruns for 10 cycles, then reads of 0..4 return 0.
- With PROG_MEM_PARITY_EN defined, force one stored bit flip at address 2, then read address 2 -> parity_err=1 with opcode_valid=1. Reading other addresses gives parity_err=0.

Source files
------------

// File: rtl/prog_mem_pkg.sv
// Shared types, default widths and the parity helper for the program memory controller.
// Optional parity storage is enabled with the PROG_MEM_PARITY_EN macro.
package prog_mem_pkg;

  typedef enum logic {
    StClear = 1'b0,
    StRun   = 1'b1
  } state_e;

  localparam int unsigned DATA_W_DEF = 26;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DEPTH_DEF  = 16;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/prog_mem_if.sv
// Loader/fetch bus of the program memory controller; master drives requests, slave answers.
// parity_err exists only when PROG_MEM_PARITY_EN is defined.
interface prog_mem_if
  import prog_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic              write_data;
  logic              wr_auto;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] data_to_write;
  logic              load_restart;
  logic              rd_en;
  logic [ADDR_W-1:0] prog_pointer;
  logic [DATA_W-1:0] opcode;
  logic              opcode_valid;
  logic              ready;
  logic [ADDR_W:0]   load_count;
  logic              load_full;
  logic              addr_err;
`ifdef PROG_MEM_PARITY_EN
  logic              parity_err;

  modport master (
    output write_data, wr_auto, wr_addr, data_to_write, load_restart, rd_en, prog_pointer,
    input  opcode, opcode_valid, ready, load_count, load_full, addr_err, parity_err
  );
  modport slave (
    input  write_data, wr_auto, wr_addr, data_to_write, load_restart, rd_en, prog_pointer,
    output opcode, opcode_valid, ready, load_count, load_full, addr_err, parity_err
  );
`else
  modport master (
    output write_data, wr_auto, wr_addr, data_to_write, load_restart, rd_en, prog_pointer,
    input  opcode, opcode_valid, ready, load_count, load_full, addr_err
  );
  modport slave (
    input  write_data, wr_auto, wr_addr, data_to_write, load_restart, rd_en, prog_pointer,
    output opcode, opcode_valid, ready, load_count, load_full, addr_err
  );
`endif
endinterface

// File: rtl/prog_mem_array.sv
// Word storage with one write port and one registered write-first read port.
// Unimplemented addresses (>= DEPTH) are never written and read back as zero.
module prog_mem_array
  import prog_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              w_ok;
  logic              r_ok;

  assign w_ok = (32'(waddr) < DEPTH);
  assign r_ok = (32'(raddr) < DEPTH);

  always_ff @(posedge clk) begin
    if (we && w_ok) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (re) begin
      if (!r_ok) begin
        rdata_q <= '0;
      end else if (we && (waddr == raddr)) begin
        rdata_q <= wdata;
      end else begin
        rdata_q <= mem[raddr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/prog_mem_ctrl.sv
// Program memory controller: clears storage after reset, then serves streamed/explicit writes
// and 1-cycle fetch reads. PROG_MEM_PARITY_EN adds per-word parity and parity_err.
module prog_mem_ctrl
  import prog_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic      clk,
  input  logic      reset,
  prog_mem_if.slave bus
);
`ifdef PROG_MEM_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned       MEM_W     = DATA_W + PAR_W;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              valid_q;
  logic              err_q, err_d;
  logic              we, re;
  logic [ADDR_W-1:0] waddr;
  logic [MEM_W-1:0]  wdata, rdata;
  logic              full, wr_oor, rd_oor, wr_str;

  assign full   = (cnt_q == DEPTH_L);
  assign wr_oor = ({1'b0, bus.wr_addr} >= DEPTH_L);
  assign rd_oor = ({1'b0, bus.prog_pointer} >= DEPTH_L);

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    waddr   = clr_q;
    wdata   = '0;
    wr_str  = 1'b0;
    unique case (state_q)
      StClear: begin
        we = 1'b1;
        if (clr_q == LAST_ADDR) begin
          state_d = StRun;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      StRun: begin
        wr_str = bus.write_data & bus.wr_auto & ~full;
        we     = wr_str | (bus.write_data & ~bus.wr_auto & ~wr_oor);
        waddr  = bus.wr_auto ? cnt_q[ADDR_W-1:0] : bus.wr_addr;
`ifdef PROG_MEM_PARITY_EN
        wdata  = {even_parity(64'(bus.data_to_write)), bus.data_to_write};
`else
        wdata  = bus.data_to_write;
`endif
        re     = bus.rd_en;
        if (wr_str) begin
          cnt_d = cnt_q + 1'b1;
        end
        // One pulse covers any mix of bad write and bad read in the same cycle.
        err_d = (bus.write_data & (bus.wr_auto ? full : wr_oor)) | (bus.rd_en & rd_oor);
      end
    endcase
    // Restart wins over the increment; the write above already used the old pointer.
    if (bus.load_restart) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StClear;
      clr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
      valid_q <= re;
      err_q   <= err_d;
    end
  end

  prog_mem_array #(
    .DATA_W (MEM_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (bus.prog_pointer),
    .rdata (rdata)
  );

  assign bus.opcode       = rdata[DATA_W-1:0];
  assign bus.opcode_valid = valid_q;
  assign bus.ready        = (state_q == StRun);
  assign bus.load_count   = cnt_q;
  assign bus.load_full    = full;
  assign bus.addr_err     = err_q;
`ifdef PROG_MEM_PARITY_EN
  assign bus.parity_err   = valid_q & (rdata[DATA_W] != even_parity(64'(rdata[DATA_W-1:0])));
`endif

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Randomised self-checking bench for prog_mem_ctrl (DEPTH=10) against an array-based model.
// Parity checks are compiled in when PROG_MEM_PARITY_EN is defined.
module tb_prog_mem_ctrl;
  localparam int unsigned DW = 26;
  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  int            m_cnt;
  int            m_clr;
  bit            m_ready;
  logic [DW-1:0] m_op;
  bit            m_valid;
  bit            m_err;
  int            m_bad_addr = -1;
  int            m_rd_addr = -1;

  prog_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  prog_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.write_data    = 1'b0;
    bus.wr_auto       = 1'b0;
    bus.wr_addr       = '0;
    bus.data_to_write = '0;
    bus.load_restart  = 1'b0;
    bus.rd_en         = 1'b0;
    bus.prog_pointer  = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_cnt = 0; m_clr = 0; m_ready = 0;
    m_op = '0; m_valid = 0; m_err = 0; m_bad_addr = -1; m_rd_addr = -1;
  endtask

  task automatic check_outputs();
    check_eq("ready", 32'(bus.ready), 32'(m_ready));
    check_eq("opcode_valid", 32'(bus.opcode_valid), 32'(m_valid));
    check_eq("opcode", 32'(bus.opcode), 32'(m_op));
    check_eq("addr_err", 32'(bus.addr_err), 32'(m_err));
    check_eq("load_count", 32'(bus.load_count), 32'(m_cnt));
    check_eq("load_full", 32'(bus.load_full), 32'(m_cnt == DEPTH));
`ifdef PROG_MEM_PARITY_EN
    check_eq("parity_err", 32'(bus.parity_err),
             32'(m_valid && m_rd_addr == m_bad_addr && m_bad_addr >= 0));
`endif
  endtask

  // One clock: model applies the cycle's inputs (write before read), then outputs are compared.
  task automatic step();
    bit err;
    @(posedge clk);
    err = 0;
    if (m_ready) begin
      if (bus.write_data) begin
        if (bus.wr_auto) begin
          if (m_cnt < DEPTH) begin
            m_mem[m_cnt] = bus.data_to_write;
            if (m_cnt == m_bad_addr) m_bad_addr = -1;
            m_cnt++;
          end else err = 1;
        end else if (int'(bus.wr_addr) < DEPTH) begin
          m_mem[bus.wr_addr] = bus.data_to_write;
          if (int'(bus.wr_addr) == m_bad_addr) m_bad_addr = -1;
        end else err = 1;
      end
      if (bus.rd_en) begin
        m_valid = 1;
        m_rd_addr = int'(bus.prog_pointer);
        if (int'(bus.prog_pointer) < DEPTH) m_op = m_mem[bus.prog_pointer];
        else begin m_op = '0; err = 1; end
      end else m_valid = 0;
    end else begin
      m_valid = 0;
      m_clr++;
      if (m_clr == DEPTH) m_ready = 1;
    end
    m_err = err;
    if (bus.load_restart) m_cnt = 0;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic read_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      idle();
      bus.rd_en = 1'b1;
      bus.prog_pointer = AW'(a);
      step();
    end
    idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_opcode"}, 32'(bus.opcode), 32'd0);
    check_eq({tag, "_valid"}, 32'(bus.opcode_valid), 32'd0);
    check_eq({tag, "_ready"}, 32'(bus.ready), 32'd0);
    check_eq({tag, "_count"}, 32'(bus.load_count), 32'd0);
    check_eq({tag, "_err"}, 32'(bus.addr_err), 32'd0);
  endtask

  initial begin
    int lat;
    logic [DW-1:0] pat;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;

    // Clear phase must take exactly DEPTH cycles
    lat = 0;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (bus.ready && lat == 0) lat = i;
    end
    check_eq("ready_latency", 32'(lat), 32'(DEPTH));
    read_range(0, DEPTH - 1);

    // Stream alternating pattern, then one write too many
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      bus.write_data = 1'b1;
      bus.wr_auto = 1'b1;
      pat = (i % 2 == 0) ? 26'h5555 : 26'hAAAA;
      bus.data_to_write = pat;
      step();
      check_eq("stream_count", 32'(bus.load_count), 32'(i + 1));
    end
    check_eq("stream_full", 32'(bus.load_full), 32'd1);
    idle();
    bus.write_data = 1'b1;
    bus.wr_auto = 1'b1;
    bus.data_to_write = 26'h3FFFFFF;
    step();
    check_eq("overflow_err", 32'(bus.addr_err), 32'd1);
    idle();
    step();
    check_eq("err_one_cycle", 32'(bus.addr_err), 32'd0);
    read_range(0, DEPTH - 1);

    // Same-cycle write and read at address 3 returns the new word
    idle();
    bus.write_data = 1'b1;
    bus.wr_addr = 4'd3;
    bus.data_to_write = 26'h2AAAAAA;
    bus.rd_en = 1'b1;
    bus.prog_pointer = 4'd3;
    step();
    check_eq("write_first", 32'(bus.opcode), 32'h2AAAAAA);

    // Out-of-range write and read together give one pulse and a zero opcode
    idle();
    bus.write_data = 1'b1;
    bus.wr_addr = 4'd12;
    bus.data_to_write = 26'h1234567;
    bus.rd_en = 1'b1;
    bus.prog_pointer = 4'd15;
    step();
    check_eq("oor_err", 32'(bus.addr_err), 32'd1);
    check_eq("oor_opcode", 32'(bus.opcode), 32'd0);
    check_eq("oor_valid", 32'(bus.opcode_valid), 32'd1);
    idle();
    step();
    check_eq("oor_single_pulse", 32'(bus.addr_err), 32'd0);
    read_range(0, DEPTH - 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.write_data    = 1'($urandom_range(0, 1));
      bus.wr_auto       = 1'($urandom_range(0, 1));
      bus.wr_addr       = AW'($urandom_range(0, 15));
      bus.data_to_write = DW'($urandom);
      bus.load_restart  = ($urandom_range(0, 15) == 0);
      bus.rd_en         = 1'($urandom_range(0, 1));
      bus.prog_pointer  = AW'($urandom_range(0, 15));
      step();
    end

    // Reset after five streamed words reruns the clear
    idle();
    bus.load_restart = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      idle();
      bus.write_data = 1'b1;
      bus.wr_auto = 1'b1;
      bus.data_to_write = DW'($urandom) | 26'h1;
      step();
    end
    idle();
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    lat = 0;
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      if (bus.ready && lat == 0) lat = i;
    end
    check_eq("reclear_latency", 32'(lat), 32'(DEPTH));
    read_range(0, 4);

`ifdef PROG_MEM_PARITY_EN
    idle();
    bus.write_data = 1'b1;
    bus.wr_addr = 4'd2;
    bus.data_to_write = 26'h0F0F0F0;
    step();
    dut.u_array.mem[2][0] = ~dut.u_array.mem[2][0];
    m_mem[2][0] = ~m_mem[2][0];
    m_bad_addr = 2;
    read_range(2, 2);
    check_eq("parity_hit", 32'(bus.parity_err), 32'd1);
    read_range(3, 3);
    check_eq("parity_clean", 32'(bus.parity_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
